// File: rtl/id_ex_shift_skid_pkg.sv
// Shared types for the ID/EX shift boundary stage: widths, ALU op codes,
// the EX-bound payload bundle and the skid-buffer state encoding.
package id_ex_shift_skid_pkg;

  localparam int EX_DATA_W  = 32;
  localparam int EX_SHAMT_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_NOR = 4'h5,
    ALU_SLT = 4'h6,
    ALU_SLL = 4'h7,
    ALU_SRL = 4'h8,
    ALU_LUI = 4'h9
  } alu_op_t;

  typedef struct packed {
    logic [EX_DATA_W-1:0]  sft_src;
    logic [EX_SHAMT_W-1:0] sft_shamt;
    logic                  left_right;
    logic [EX_DATA_W-1:0]  rs_data;
    alu_op_t               alu_op;
    logic [4:0]            rd;
    logic                  reg_write;
  } ex_bundle_t;

  localparam int BUNDLE_W = $bits(ex_bundle_t);

  // Encoding is {main_v, skid_v}; 2'b01 can only appear through upset.
  typedef enum logic [1:0] {
    SK_EMPTY = 2'b00,
    SK_BAD   = 2'b01,
    SK_MAIN  = 2'b10,
    SK_FULL  = 2'b11
  } skid_state_t;

endpackage

// File: rtl/id_ex_shift_skid_if.sv
// ID-side and EX-side signal bundle of the ID/EX shift stage.
interface id_ex_shift_skid_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 16
);
    logic               flush_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [DATA_W-1:0]  rs_data_i;
    logic [DATA_W-1:0]  rt_data_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic               shift_var_i;
    logic               left_right_i;
    logic [3:0]         alu_op_i;
    logic [4:0]         rd_i;
    logic               reg_write_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [DATA_W-1:0]  sft_src_o;
    logic [SHAMT_W-1:0] sft_shamt_o;
    logic               left_right_o;
    logic [DATA_W-1:0]  rs_data_o;
    logic [3:0]         alu_op_o;
    logic [4:0]         rd_o;
    logic               reg_write_o;
    logic [CNT_W-1:0]   stall_cnt_o;

    // The stage itself.
    modport slave (
        input  flush_i, in_valid_i, rs_data_i, rt_data_i, shamt_i,
               shift_var_i, left_right_i, alu_op_i, rd_i, reg_write_i,
               out_ready_i,
        output in_ready_o, out_valid_o, sft_src_o, sft_shamt_o,
               left_right_o, rs_data_o, alu_op_o, rd_o, reg_write_o,
               stall_cnt_o
    );

    // The surrounding pipeline (ID producer plus EX consumer).
    modport master (
        output flush_i, in_valid_i, rs_data_i, rt_data_i, shamt_i,
               shift_var_i, left_right_i, alu_op_i, rd_i, reg_write_i,
               out_ready_i,
        input  in_ready_o, out_valid_o, sft_src_o, sft_shamt_o,
               left_right_o, rs_data_o, alu_op_o, rd_o, reg_write_o,
               stall_cnt_o
    );
endinterface

// File: rtl/id_ex_shift_skid_skid_buffer.sv
// Two-entry skid buffer with a registered upstream ready; the output is
// always driven from the main entry so it stays stable under back-pressure.
module skid_buffer
    import id_ex_shift_skid_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state_q, state_d;
    logic         in_ready_q;
    logic         vld_p1, vld_p0;
    logic [W-1:0] main_p1, skid_p0;
    logic         accept, consume;
    logic         ld_main_in, ld_main_skid, ld_skid;

    assign {vld_p1, vld_p0} = state_q;
    assign accept    = in_valid & in_ready_q;
    assign consume   = vld_p1 & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = vld_p1;
    assign out_data  = main_p1;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            SK_EMPTY: begin
                if (accept) begin
                    state_d    = SK_MAIN;
                    ld_main_in = 1'b1;
                end
            end
            SK_MAIN: begin
                case ({accept, consume})
                    2'b01: state_d = SK_EMPTY;
                    2'b11: ld_main_in = 1'b1;
                    2'b10: begin
                        state_d = SK_FULL;
                        ld_skid = 1'b1;
                    end
                    default: state_d = SK_MAIN;
                endcase
            end
            SK_FULL: begin
                if (consume) begin
                    state_d      = SK_MAIN;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_d = SK_EMPTY;
        endcase
        // Squash wins over any transfer; payload is left as it was.
        if (flush) begin
            state_d      = SK_EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    // Control: state and the registered ready (= !skid_v of next state).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SK_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= ~state_d[0];
        end
    end

    // Payload: main entry (p1) feeds EX, skid entry (p0) catches overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_p1 <= '0;
            skid_p0 <= '0;
        end else begin
            if (ld_main_in)
                main_p1 <= in_data;
            else if (ld_main_skid)
                main_p1 <= skid_p0;
            if (ld_skid)
                skid_p0 <= in_data;
        end
    end

endmodule

// File: rtl/id_ex_shift_skid.sv
// ID/EX boundary for the shifter/ALU: resolves the effective shift amount at
// capture, buffers through a skid buffer and counts back-pressured cycles.
module id_ex_shift_skid
    import id_ex_shift_skid_pkg::*;
#(
    parameter int DATA_W  = EX_DATA_W,
    parameter int SHAMT_W = EX_SHAMT_W,
    parameter int CNT_W   = 16
) (
    input logic              clk_i,
    input logic              rst_i,
    id_ex_shift_skid_if.slave bus
);

    ex_bundle_t       in_b, out_b;
    logic [DATA_W-1:0] rs_in;
    logic [CNT_W-1:0]  stall_q;

    // Variable shifts take only the low rs bits; upper bits are ignored.
    function automatic logic [SHAMT_W-1:0] eff_shamt(
        input logic               shift_var,
        input logic [DATA_W-1:0]  rs,
        input logic [SHAMT_W-1:0] shamt
    );
        return shift_var ? rs[SHAMT_W-1:0] : shamt;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign rs_in = bus.rs_data_i;

    // Stage p0: form the EX bundle from ID inputs.
    always_comb begin
        in_b.sft_src    = bus.rt_data_i;
        in_b.sft_shamt  = eff_shamt(bus.shift_var_i, rs_in, bus.shamt_i);
        in_b.left_right = bus.left_right_i;
        in_b.rs_data    = rs_in;
        in_b.alu_op     = alu_op_t'(bus.alu_op_i);
        in_b.rd         = bus.rd_i;
        in_b.reg_write  = bus.reg_write_i;
    end

    skid_buffer #(
        .W(BUNDLE_W)
    ) u_skid (
        .clk      (clk_i),
        .rst      (rst_i),
        .flush    (bus.flush_i),
        .in_valid (bus.in_valid_i),
        .in_ready (bus.in_ready_o),
        .in_data  (in_b),
        .out_valid(bus.out_valid_o),
        .out_ready(bus.out_ready_i),
        .out_data (out_b)
    );

    // Stage p1: main entry drives EX.
    assign bus.sft_src_o    = out_b.sft_src;
    assign bus.sft_shamt_o  = out_b.sft_shamt;
    assign bus.left_right_o = out_b.left_right;
    assign bus.rs_data_o    = out_b.rs_data;
    assign bus.alu_op_o     = out_b.alu_op;
    assign bus.rd_o         = out_b.rd;
    assign bus.reg_write_o  = out_b.reg_write;

    // Flush does not touch the counter; only reset clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            stall_q <= '0;
        else if (bus.out_valid_o & ~bus.out_ready_i)
            stall_q <= sat_inc(stall_q);
    end

    assign bus.stall_cnt_o = stall_q;

endmodule

// File: tb/tb_id_ex_shift_skid.sv
// Directed bench for id_ex_shift_skid: vector table plus async-reset and
// counter-saturation sequences.
module tb_id_ex_shift_skid;
  import id_ex_shift_skid_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_shift_skid_if #(.DATA_W(32), .SHAMT_W(5), .CNT_W(16)) ifm ();
  id_ex_shift_skid_if #(.DATA_W(32), .SHAMT_W(5), .CNT_W(4))  ifs ();

  id_ex_shift_skid #(.DATA_W(32), .SHAMT_W(5), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .bus(ifm.slave)
  );

  id_ex_shift_skid #(.DATA_W(32), .SHAMT_W(5), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .bus(ifs.slave)
  );

  typedef struct {
    logic        fl, iv;
    logic [31:0] rs, rt;
    logic [4:0]  sh;
    logic        sv, lr;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw, ordy;
    logic        e_ov, e_ir, e_pl;
    logic [31:0] e_src;
    logic [4:0]  e_sh;
    logic        e_lr;
    logic [31:0] e_rs;
    logic [3:0]  e_op;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    ifm.flush_i      = v.fl;
    ifm.in_valid_i   = v.iv;
    ifm.rs_data_i    = v.rs;
    ifm.rt_data_i    = v.rt;
    ifm.shamt_i      = v.sh;
    ifm.shift_var_i  = v.sv;
    ifm.left_right_i = v.lr;
    ifm.alu_op_i     = v.op;
    ifm.rd_i         = v.rd;
    ifm.reg_write_i  = v.rw;
    ifm.out_ready_i  = v.ordy;
  endtask

  task automatic idle_sat();
    ifs.flush_i = 1'b0; ifs.in_valid_i = 1'b0; ifs.rs_data_i = '0;
    ifs.rt_data_i = '0; ifs.shamt_i = '0; ifs.shift_var_i = 1'b0;
    ifs.left_right_i = 1'b0; ifs.alu_op_i = '0; ifs.rd_i = '0;
    ifs.reg_write_i = 1'b0; ifs.out_ready_i = 1'b1;
  endtask

  initial begin
    vec_t idle;
    idle = '{1'b0,1'b0,32'h0,32'h0,5'd0,1'b0,1'b0,4'd0,5'd0,1'b0,1'b1,
             1'b0,1'b0,1'b0,32'h0,5'd0,1'b0,32'h0,4'd0,5'd0,1'b0,16'd0};
    //          fl   iv   rs            rt            sh    sv   lr   op    rd     rw   ordy   ov   ir   pl   src           sh     lr   rs            op    rd     rw   cnt
    vecs[0]  = '{1'b0,1'b1,32'h0000_1234,32'h8000_0000,5'd4, 1'b0,1'b0,4'd8,5'd3, 1'b1,1'b1, 1'b1,1'b1,1'b1,32'h8000_0000,5'd4, 1'b0,32'h0000_1234,4'd8,5'd3, 1'b1,16'd0};
    vecs[1]  = '{1'b0,1'b1,32'h0000_0025,32'h0000_0001,5'd31,1'b1,1'b1,4'd7,5'd5, 1'b1,1'b1, 1'b1,1'b1,1'b1,32'h0000_0001,5'd5, 1'b1,32'h0000_0025,4'd7,5'd5, 1'b1,16'd0};
    vecs[2]  = '{1'b0,1'b0,32'h0,         32'h0,         5'd0, 1'b0,1'b0,4'd0,5'd0, 1'b0,1'b1, 1'b0,1'b1,1'b0,32'h0,         5'd0, 1'b0,32'h0,         4'd0,5'd0, 1'b0,16'd0};
    vecs[3]  = '{1'b0,1'b1,32'h0000_0100,32'h0000_000A,5'd1, 1'b0,1'b1,4'd7,5'd10,1'b1,1'b0, 1'b1,1'b1,1'b1,32'h0000_000A,5'd1, 1'b1,32'h0000_0100,4'd7,5'd10,1'b1,16'd0};
    vecs[4]  = '{1'b0,1'b1,32'h0000_0200,32'h0000_000B,5'd2, 1'b0,1'b0,4'd8,5'd11,1'b0,1'b0, 1'b1,1'b0,1'b1,32'h0000_000A,5'd1, 1'b1,32'h0000_0100,4'd7,5'd10,1'b1,16'd1};
    vecs[5]  = '{1'b0,1'b1,32'h0000_0033,32'h0000_000C,5'd3, 1'b1,1'b1,4'd7,5'd12,1'b1,1'b0, 1'b1,1'b0,1'b1,32'h0000_000A,5'd1, 1'b1,32'h0000_0100,4'd7,5'd10,1'b1,16'd2};
    vecs[6]  = '{1'b0,1'b1,32'h0000_0033,32'h0000_000C,5'd3, 1'b1,1'b1,4'd7,5'd12,1'b1,1'b0, 1'b1,1'b0,1'b1,32'h0000_000A,5'd1, 1'b1,32'h0000_0100,4'd7,5'd10,1'b1,16'd3};
    vecs[7]  = '{1'b0,1'b1,32'h0000_0033,32'h0000_000C,5'd3, 1'b1,1'b1,4'd7,5'd12,1'b1,1'b1, 1'b1,1'b1,1'b1,32'h0000_000B,5'd2, 1'b0,32'h0000_0200,4'd8,5'd11,1'b0,16'd3};
    vecs[8]  = '{1'b0,1'b1,32'h0000_0033,32'h0000_000C,5'd3, 1'b1,1'b1,4'd7,5'd12,1'b1,1'b1, 1'b1,1'b1,1'b1,32'h0000_000C,5'd19,1'b1,32'h0000_0033,4'd7,5'd12,1'b1,16'd3};
    vecs[9]  = '{1'b0,1'b0,32'h0,         32'h0,         5'd0, 1'b0,1'b0,4'd0,5'd0, 1'b0,1'b1, 1'b0,1'b1,1'b0,32'h0,         5'd0, 1'b0,32'h0,         4'd0,5'd0, 1'b0,16'd3};
    vecs[10] = '{1'b0,1'b1,32'h0000_0400,32'h0000_000D,5'd6, 1'b0,1'b0,4'd8,5'd13,1'b1,1'b0, 1'b1,1'b1,1'b1,32'h0000_000D,5'd6, 1'b0,32'h0000_0400,4'd8,5'd13,1'b1,16'd3};
    vecs[11] = '{1'b0,1'b1,32'h0000_0500,32'h0000_000E,5'd8, 1'b0,1'b1,4'd7,5'd14,1'b1,1'b0, 1'b1,1'b0,1'b1,32'h0000_000D,5'd6, 1'b0,32'h0000_0400,4'd8,5'd13,1'b1,16'd4};
    vecs[12] = '{1'b1,1'b1,32'h0000_0600,32'h0000_000F,5'd9, 1'b0,1'b0,4'd8,5'd15,1'b1,1'b1, 1'b0,1'b1,1'b0,32'h0,         5'd0, 1'b0,32'h0,         4'd0,5'd0, 1'b0,16'd4};
    vecs[13] = '{1'b0,1'b0,32'h0,         32'h0,         5'd0, 1'b0,1'b0,4'd0,5'd0, 1'b0,1'b1, 1'b0,1'b1,1'b0,32'h0,         5'd0, 1'b0,32'h0,         4'd0,5'd0, 1'b0,16'd4};
    vecs[14] = '{1'b0,1'b1,32'h0000_0700,32'h0000_0006,5'd7, 1'b0,1'b0,4'd8,5'd16,1'b1,1'b1, 1'b1,1'b1,1'b1,32'h0000_0006,5'd7, 1'b0,32'h0000_0700,4'd8,5'd16,1'b1,16'd4};
    vecs[15] = '{1'b0,1'b0,32'h0,         32'h0,         5'd0, 1'b0,1'b0,4'd0,5'd0, 1'b0,1'b1, 1'b0,1'b1,1'b0,32'h0,         5'd0, 1'b0,32'h0,         4'd0,5'd0, 1'b0,16'd4};

    drive(idle);
    idle_sat();
    #1 rst = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(ifm.out_valid_o), 32'h0);
    chk("rst_in_ready",  32'(ifm.in_ready_o),  32'h1);
    chk("rst_stall_cnt", 32'(ifm.stall_cnt_o), 32'h0);
    chk("rst_sft_src",   ifm.sft_src_o,        32'h0);
    rst = 1'b0;
    #2;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      step();
      chk($sformatf("v%0d_out_valid", i), 32'(ifm.out_valid_o), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_in_ready", i),  32'(ifm.in_ready_o),  32'(vecs[i].e_ir));
      chk($sformatf("v%0d_stall_cnt", i), 32'(ifm.stall_cnt_o), 32'(vecs[i].e_cnt));
      if (vecs[i].e_pl) begin
        chk($sformatf("v%0d_sft_src", i),   ifm.sft_src_o,         vecs[i].e_src);
        chk($sformatf("v%0d_sft_shamt", i), 32'(ifm.sft_shamt_o),  32'(vecs[i].e_sh));
        chk($sformatf("v%0d_left_right", i),32'(ifm.left_right_o), 32'(vecs[i].e_lr));
        chk($sformatf("v%0d_rs_data", i),   ifm.rs_data_o,         vecs[i].e_rs);
        chk($sformatf("v%0d_alu_op", i),    32'(ifm.alu_op_o),     32'(vecs[i].e_op));
        chk($sformatf("v%0d_rd", i),        32'(ifm.rd_o),         32'(vecs[i].e_rd));
        chk($sformatf("v%0d_reg_write", i), 32'(ifm.reg_write_o),  32'(vecs[i].e_rw));
      end
      if (i == 1)
        chk("sllv_shifter_result",
            ifm.left_right_o ? (ifm.sft_src_o << ifm.sft_shamt_o)
                             : (ifm.sft_src_o >> ifm.sft_shamt_o),
            32'h0000_0020);
    end

    // Fill both entries, then pull reset between clock edges.
    ifm.in_valid_i = 1'b1; ifm.out_ready_i = 1'b0; ifm.flush_i = 1'b0;
    ifm.shift_var_i = 1'b0; ifm.rt_data_i = 32'h0000_0111; ifm.shamt_i = 5'd1;
    step();
    ifm.rt_data_i = 32'h0000_0222; ifm.shamt_i = 5'd2;
    step();
    chk("full_in_ready",  32'(ifm.in_ready_o),  32'h0);
    chk("full_out_valid", 32'(ifm.out_valid_o), 32'h1);
    chk("full_stall_cnt", 32'(ifm.stall_cnt_o), 32'h5);
    chk("full_sft_src",   ifm.sft_src_o,        32'h0000_0111);
    ifm.in_valid_i = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(ifm.out_valid_o), 32'h0);
    chk("async_rst_in_ready",  32'(ifm.in_ready_o),  32'h1);
    chk("async_rst_stall_cnt", 32'(ifm.stall_cnt_o), 32'h0);
    chk("async_rst_sft_src",   ifm.sft_src_o,        32'h0);
    #2 rst = 1'b0;
    ifm.in_valid_i = 1'b1; ifm.out_ready_i = 1'b1;
    ifm.rt_data_i = 32'hCAFE_0001; ifm.shamt_i = 5'd9;
    step();
    chk("post_rst_out_valid", 32'(ifm.out_valid_o), 32'h1);
    chk("post_rst_sft_src",   ifm.sft_src_o,        32'hCAFE_0001);
    chk("post_rst_sft_shamt", 32'(ifm.sft_shamt_o), 32'd9);
    ifm.in_valid_i = 1'b0;
    step();
    chk("post_rst_drain", 32'(ifm.out_valid_o), 32'h0);

    // Narrow counter: one held entry stalled for 20 cycles.
    ifs.in_valid_i = 1'b1; ifs.rt_data_i = 32'h0000_0055; ifs.out_ready_i = 1'b0;
    step();
    ifs.in_valid_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14)
        chk("sat_cnt_14", 32'(ifs.stall_cnt_o), 32'd14);
    end
    chk("sat_cnt_20", 32'(ifs.stall_cnt_o), 32'd15);
    step();
    chk("sat_cnt_held",   32'(ifs.stall_cnt_o), 32'd15);
    chk("sat_out_valid",  32'(ifs.out_valid_o), 32'h1);
    chk("sat_sft_src",    ifs.sft_src_o,        32'h0000_0055);
    ifs.out_ready_i = 1'b1;
    step();
    chk("sat_drained",    32'(ifs.out_valid_o), 32'h0);
    chk("sat_cnt_kept",   32'(ifs.stall_cnt_o), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
